// File: rtl/fuzzy_frame_ctrl.sv
// fuzzy_frame_ctrl
//   Sequencer in front of the fuzzy risk engine. Collects N_IN operand bytes
//   from the pad bus (one per rising edge of the async strobe ss), fires one
//   engine evaluation, waits for the result with a timeout, and holds the
//   last risk byte until the next frame completes.
// Ports
//   clk, rst_n          clock, async active-low reset
//   ss, data_bus        pad strobe (async) and operand byte
//   eng_in, eng_start   operand vector (byte k at [8k+7:8k]) and start pulse
//   eng_done, eng_risk  engine result strobe and value
//   risk, risk_valid    last captured result and its validity
//   busy, err           START/WAIT indicator, sticky timeout flag
module fuzzy_frame_ctrl #(
  parameter int N_IN    = 3,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ss,
  input  logic [7:0]          data_bus,
  output logic [8*N_IN-1:0]   eng_in,
  output logic                eng_start,
  input  logic                eng_done,
  input  logic [7:0]          eng_risk,
  output logic [7:0]          risk,
  output logic                risk_valid,
  output logic                busy,
  output logic                err
);

  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_IN - 1);
  localparam logic [TMR_W-1:0] LAST_TICK = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_t;

  state_t                 state, state_d;
  logic [1:0]             ss_pipe;
  logic                   edge_q;
  logic                   stb;
  logic [N_IN-1:0][7:0]   bytes_q, bytes_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [7:0]             risk_d;
  logic                   risk_valid_d, err_d;

  // Two-flop synchroniser plus edge register; data_bus is not synchronised
  // because the pad protocol keeps it stable until ss falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_pipe <= '0;
      edge_q  <= 1'b0;
    end else begin
      ss_pipe <= {ss_pipe[0], ss};
      edge_q  <= ss_pipe[1];
    end
  end

  assign stb = ss_pipe[1] & ~edge_q;

  always_comb begin
    state_d      = state;
    bytes_d      = bytes_q;
    idx_d        = idx_q;
    timer_d      = timer_q;
    risk_d       = risk;
    risk_valid_d = risk_valid;
    err_d        = err;
    case (state)
      IDLE: if (stb) begin
        bytes_d[0] = data_bus;
        idx_d      = IDX_W'(1);
        err_d      = 1'b0;
        state_d    = LOAD;
      end
      LOAD: if (stb) begin
        bytes_d[idx_q] = data_bus;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = START;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      START: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + 1'b1;
        // done beats a coincident timeout
        if (eng_done) begin
          risk_d       = eng_risk;
          risk_valid_d = 1'b1;
          state_d      = IDLE;
        end else if (timer_q == LAST_TICK) begin
          err_d        = 1'b1;
          risk_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bytes_q    <= '0;
      idx_q      <= '0;
      timer_q    <= '0;
      risk       <= '0;
      risk_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_d;
      bytes_q    <= bytes_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      risk       <= risk_d;
      risk_valid <= risk_valid_d;
      err        <= err_d;
    end
  end

  assign eng_in    = bytes_q;
  assign eng_start = (state == START);
  assign busy      = (state == START) || (state == WAIT);

endmodule

// File: tb/tb_fuzzy_frame_ctrl.sv
// Scoreboard bench for fuzzy_frame_ctrl: the driver pushes the expected
// operand vector and frame result; a monitor pops them when eng_start
// pulses or busy falls, and checks risk/risk_valid hold every cycle.
module tb_fuzzy_frame_ctrl;
  localparam int N  = 3;
  localparam int TO = 20;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ss = 1'b0;
  logic [7:0]       data_bus = '0;
  logic [8*N-1:0]   eng_in;
  logic             eng_start;
  logic             eng_done = 1'b0;
  logic [7:0]       eng_risk = '0;
  logic [7:0]       risk;
  logic             risk_valid, busy, err;

  fuzzy_frame_ctrl #(.N_IN(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ss(ss), .data_bus(data_bus),
    .eng_in(eng_in), .eng_start(eng_start), .eng_done(eng_done),
    .eng_risk(eng_risk), .risk(risk), .risk_valid(risk_valid),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rk;
    logic       vld;
    logic       er;
    int         lat;
  } res_t;

  logic [8*N-1:0] exp_in_q[$];
  res_t           res_q[$];
  int             checks = 0;
  int             errors = 0;
  int             cyc = 0;

  // driver-side model of the last completed frame
  logic [7:0] model_risk = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  logic [7:0] cur_risk = '0;
  logic       cur_valid = 1'b0;
  logic       prev_busy = 1'b0;
  int         start_cyc = 0;
  res_t       mr;
  logic [8*N-1:0] me;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_in_q.delete();
      res_q.delete();
      cur_risk  = '0;
      cur_valid = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (eng_start) begin
        if (exp_in_q.size() == 0) begin
          chk("unexpected_eng_start", 1, 0);
        end else begin
          me = exp_in_q.pop_front();
          chk("eng_in", eng_in, me);
        end
        start_cyc = cyc;
      end
      if (prev_busy && !busy) begin
        if (res_q.size() == 0) begin
          chk("unexpected_frame_end", 1, 0);
        end else begin
          mr = res_q.pop_front();
          chk("risk", risk, mr.rk);
          chk("risk_valid", risk_valid, mr.vld);
          chk("err", err, mr.er);
          chk("done_latency", cyc - start_cyc, mr.lat);
          cur_risk  = mr.rk;
          cur_valid = mr.vld;
        end
      end
      chk("risk_hold", risk, cur_risk);
      chk("risk_valid_hold", risk_valid, cur_valid);
      prev_busy = busy;
    end
  end

  // ---------------- driver ----------------
  task automatic send_byte(input logic [7:0] b, input int hi, input int lo);
    data_bus = b;
    ss = 1'b1;
    repeat (hi) @(negedge clk);
    ss = 1'b0;
    repeat (lo) @(negedge clk);
    data_bus = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < TO + 10) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("busy_timeout", busy, 0);
  endtask

  // d: cycle (relative to eng_start) at which eng_done is raised; 0 = never
  task automatic run_frame(input logic [8*N-1:0] v, input int d, input bit drop,
                           input logic [7:0] rr, input int hi);
    int n = 0;
    int k = 0;
    res_t r;
    for (int i = 0; i < N - 1; i++)
      send_byte(v[8*i +: 8], hi, $urandom_range(3, 6));
    exp_in_q.push_back(v);
    data_bus = v[8*(N-1) +: 8];
    ss = 1'b1;
    while (!eng_start && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!eng_start) begin
      chk("eng_start_seen", 0, 1);
      ss = 1'b0;
      return;
    end
    ss = 1'b0;
    if (d == 0 || d > TO) begin
      r.rk = model_risk; r.vld = 1'b0; r.er = 1'b1; r.lat = TO + 1;
    end else begin
      r.rk = rr; r.vld = 1'b1; r.er = 1'b0; r.lat = d + 1;
      model_risk = rr;
    end
    res_q.push_back(r);
    if (drop) begin
      repeat (3) begin @(negedge clk); k++; end
      data_bus = 8'($urandom);
      ss = 1'b1;
      repeat (4) begin @(negedge clk); k++; end
      ss = 1'b0;
    end
    if (d == 0) begin
      while (busy && k < TO + 8) begin @(negedge clk); k++; end
    end else begin
      while (k < d) begin @(negedge clk); k++; end
      eng_risk = rr;
      eng_done = 1'b1;
      @(negedge clk);
      eng_done = 1'b0;
      eng_risk = 8'($urandom);
    end
    wait_idle();
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_eng_in", eng_in, 0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_risk", risk, 0);
    chk("rst_risk_valid", risk_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    model_risk = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [8*N-1:0] v;
    int d;
    bit drop;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_no_start", eng_start, 0);
      chk("idle_busy", busy, 0);
    end
    // directed frame
    run_frame(24'h563412, 4, 1'b0, 8'hA7, 4);
    chk("frame_err", err, 0);
    // timeout, then a frame whose first byte clears err
    run_frame(24'($urandom), 0, 1'b0, 8'h00, 4);
    chk("timeout_err_sticky", err, 1);
    send_byte(8'h5A, 4, 4);
    chk("err_cleared_first_byte", err, 0);
    send_byte(8'h6B, 4, 4);
    begin
      logic [8*N-1:0] tail;
      tail = 24'($urandom);
      tail[15:0] = 16'h6B5A;
      exp_in_q.push_back(tail);
      data_bus = tail[23:16];
      ss = 1'b1;
      repeat (6) @(negedge clk);
      ss = 1'b0;
      // no eng_done: second timeout in a row
      res_q.push_back('{rk: model_risk, vld: 1'b0, er: 1'b1, lat: TO + 1});
      wait_idle();
      repeat (2) @(negedge clk);
    end
    run_frame(24'($urandom), 7, 1'b0, 8'($urandom), 5);
    // strobe during WAIT is dropped
    run_frame(24'($urandom), 15, 1'b1, 8'($urandom), 4);
    run_frame(24'($urandom), 3, 1'b0, 8'($urandom), 4);
    // done on the final timeout cycle wins
    run_frame(24'($urandom), TO, 1'b0, 8'($urandom), 4);
    chk("race_err", err, 0);
    // done one cycle too late: timeout, late done ignored in IDLE
    run_frame(24'($urandom), TO + 1, 1'b0, 8'($urandom), 4);
    // reset mid-LOAD after two bytes
    send_byte(8'hEE, 4, 4);
    send_byte(8'hDD, 4, 4);
    pulse_reset();
    repeat (3) @(negedge clk);
    run_frame(24'hC3B2A1, 2, 1'b0, 8'h3C, 4);
    // reset mid-WAIT, then a late eng_done after release
    begin
      v = 24'($urandom);
      for (int i = 0; i < N - 1; i++) send_byte(v[8*i +: 8], 4, 4);
      exp_in_q.push_back(v);
      data_bus = v[8*(N-1) +: 8];
      ss = 1'b1;
      repeat (8) @(negedge clk);
      ss = 1'b0;
      pulse_reset();
      @(negedge clk);
      eng_risk = 8'hFF;
      eng_done = 1'b1;
      @(negedge clk);
      eng_done = 1'b0;
      repeat (3) @(negedge clk);
      chk("late_done_risk", risk, 0);
      chk("late_done_valid", risk_valid, 0);
    end
    // randomized frames
    for (int f = 0; f < 24; f++) begin
      d = $urandom_range(0, TO + 2);
      drop = (d >= 12 && d <= TO) ? 1'($urandom) : 1'b0;
      run_frame(24'($urandom), d, drop, 8'($urandom), $urandom_range(3, 12));
      if ($urandom_range(0, 1) == 1) begin
        eng_risk = 8'($urandom);
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        @(negedge clk);
      end
    end
    repeat (5) @(negedge clk);
    chk("result_queue_drained", res_q.size(), 0);
    chk("eng_in_queue_drained", exp_in_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
